// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } hz_state_e;

  localparam int DRAIN_CYCLES_DEF = 3;

  // Bit positions of the per-stage enable/clear vectors.
  localparam int STG_PC    = 0;
  localparam int STG_IFID  = 1;
  localparam int STG_IDEX  = 2;
  localparam int STG_EXMEM = 3;
  localparam int STG_MEMWB = 4;
  localparam int NUM_STG   = 5;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare between the ID sources and the EX load destination.
module pipe_hazard_ctrl_hazard_detect (
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_use_rs,
  input  logic       i_id_use_rt,
  input  logic       i_ex_rmem,
  input  logic [4:0] i_ex_nd,
  output logic       o_luh
);

  logic w_rs_hit;
  logic w_rt_hit;

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  always_comb begin
    w_rs_hit = i_id_use_rs && (i_id_rs == i_ex_nd);
    w_rt_hit = i_id_use_rt && (i_id_rt == i_ex_nd);
    o_luh    = i_ex_rmem && (i_ex_nd != 5'd0) && (w_rs_hit || w_rt_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer driving PC and stage-register enables/clears.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow; redirect / load-use / halt handled per cycle
// MEM_WAIT | data memory stalled; upstream frozen, bubbles into MEM/WB
// DRAIN    | fetch frozen, bubbles pushed until the back end is empty
// HALTED   | everything frozen until halt_req drops
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_RMEM,
  input  logic [4:0]       ex_nd,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             pc_CE,
  output logic             ifid_CE,
  output logic             idex_CE,
  output logic             exmem_CE,
  output logic             memwb_CE,
  output logic             ifid_clr,
  output logic             idex_clr,
  output logic             memwb_clr,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  hz_state_e            r_state, w_state_nxt;
  hz_state_e            r_ret, w_ret_nxt;
  hz_state_e            w_eff;
  logic [DW-1:0]        r_dcnt, w_dcnt_nxt;
  logic [CNT_W-1:0]     r_stall_cnt;
  logic [NUM_STG-1:0]   w_ce, w_clr;
  logic                 w_luh, w_mw;

  pipe_hazard_ctrl_hazard_detect u_hazard_detect (
    .i_id_rs     (id_rs),
    .i_id_rt     (id_rt),
    .i_id_use_rs (id_use_rs),
    .i_id_use_rt (id_use_rt),
    .i_ex_rmem   (ex_RMEM),
    .i_ex_nd     (ex_nd),
    .o_luh       (w_luh)
  );

  // Next-state and stage controls; the cycle a memory wait ends behaves as the recorded return state.
  always_comb begin
    w_ce        = '1;
    w_clr       = '0;
    w_state_nxt = r_state;
    w_ret_nxt   = r_ret;
    w_dcnt_nxt  = r_dcnt;
    w_mw        = mem_req && !mem_ready;
    w_eff       = (r_state == ST_MEM_WAIT) ? r_ret : r_state;

    if (r_state == ST_HALTED) begin
      w_ce = '0;
      if (!halt_req) w_state_nxt = ST_RUN;
    end else if (w_mw) begin
      w_ce             = '0;
      w_ce[STG_MEMWB]  = 1'b1;
      w_clr[STG_MEMWB] = 1'b1;
      w_state_nxt      = ST_MEM_WAIT;
      if (r_state != ST_MEM_WAIT) w_ret_nxt = r_state;
    end else if (w_eff == ST_DRAIN) begin
      w_ce[STG_PC]    = 1'b0;
      w_ce[STG_IFID]  = 1'b0;
      w_clr[STG_IDEX] = 1'b1;
      // Flushing IF/ID needs its enable, since a clear only acts when enabled.
      if (ex_redirect) begin
        w_ce[STG_IFID]  = 1'b1;
        w_clr[STG_IFID] = 1'b1;
      end
      if (r_dcnt == '0) begin
        w_state_nxt = ST_HALTED;
      end else begin
        w_dcnt_nxt  = r_dcnt - DW'(1);
        w_state_nxt = ST_DRAIN;
      end
    end else begin
      w_state_nxt = ST_RUN;
      if (ex_redirect) begin
        w_clr[STG_IFID] = 1'b1;
        w_clr[STG_IDEX] = 1'b1;
      end else if (w_luh) begin
        w_ce[STG_PC]    = 1'b0;
        w_ce[STG_IFID]  = 1'b0;
        w_clr[STG_IDEX] = 1'b1;
      end else if (halt_req) begin
        w_ce[STG_PC]    = 1'b0;
        w_ce[STG_IFID]  = 1'b0;
        w_clr[STG_IDEX] = 1'b1;
        w_dcnt_nxt      = DW'(DRAIN_CYCLES - 1);
        w_state_nxt     = ST_DRAIN;
      end
    end
  end

  // State, return state, drain counter and saturating stall counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_ret       <= ST_RUN;
      r_dcnt      <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ret   <= w_ret_nxt;
      r_dcnt  <= w_dcnt_nxt;
      if (!w_ce[STG_PC] && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // Controls are forced inactive for as long as reset is held.
  always_comb begin
    pc_CE     = rst && w_ce[STG_PC];
    ifid_CE   = rst && w_ce[STG_IFID];
    idex_CE   = rst && w_ce[STG_IDEX];
    exmem_CE  = rst && w_ce[STG_EXMEM];
    memwb_CE  = rst && w_ce[STG_MEMWB];
    ifid_clr  = rst && w_clr[STG_IFID];
    idex_clr  = rst && w_clr[STG_IDEX];
    memwb_clr = rst && w_clr[STG_MEMWB];
    halted    = (r_state == ST_HALTED);
    stall_cnt = r_stall_cnt;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_nd;
  logic        id_use_rs, id_use_rt, ex_RMEM, ex_redirect, mem_req, mem_ready, halt_req;
  logic        pc_CE, ifid_CE, idex_CE, exmem_CE, memwb_CE;
  logic        ifid_clr, idex_clr, memwb_clr, halted;
  logic [15:0] stall_cnt;

  int errs   = 0;
  int checks = 0;

  // {pc,ifid,idex,exmem,memwb CE, ifid,idex,memwb clr, halted}
  localparam logic [8:0] E_RUN = 9'b11111_000_0;
  localparam logic [8:0] E_LUH = 9'b00111_010_0;
  localparam logic [8:0] E_RED = 9'b11111_110_0;
  localparam logic [8:0] E_MW  = 9'b00001_001_0;
  localparam logic [8:0] E_DR  = 9'b00111_010_0;
  localparam logic [8:0] E_DRR = 9'b01111_110_0;
  localparam logic [8:0] E_HL  = 9'b00000_000_1;
  localparam logic [8:0] E_OFF = 9'b00000_000_0;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       rmem;
    logic [4:0] nd;
    logic       redir;
    logic       mreq;
    logic       mrdy;
    logic       halt;
    logic [8:0] exp;
  } vec_t;

  pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_RMEM(ex_RMEM), .ex_nd(ex_nd), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req),
    .pc_CE(pc_CE), .ifid_CE(ifid_CE), .idex_CE(idex_CE), .exmem_CE(exmem_CE), .memwb_CE(memwb_CE),
    .ifid_clr(ifid_clr), .idex_clr(idex_clr), .memwb_clr(memwb_clr),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                              input logic urt, input logic rmem, input logic [4:0] nd,
                              input logic redir, input logic mreq, input logic mrdy,
                              input logic halt, input logic [8:0] exp);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.rmem = rmem; v.nd = nd;
    v.redir = redir; v.mreq = mreq; v.mrdy = mrdy; v.halt = halt; v.exp = exp;
    return v;
  endfunction

  function automatic logic [8:0] outs();
    return {pc_CE, ifid_CE, idex_CE, exmem_CE, memwb_CE, ifid_clr, idex_clr, memwb_clr, halted};
  endfunction

  task automatic drive(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; id_use_rs = v.urs; id_use_rt = v.urt;
    ex_RMEM = v.rmem; ex_nd = v.nd; ex_redirect = v.redir;
    mem_req = v.mreq; mem_ready = v.mrdy; halt_req = v.halt;
  endtask

  task automatic chk_out(input logic [8:0] exp, input string nm, input int idx);
    checks++;
    if (outs() !== exp) begin
      errs++;
      $display("FAIL %s[%0d]: got %b expected %b", nm, idx, outs(), exp);
    end
  endtask

  task automatic chk_cnt(input logic [15:0] exp, input string nm);
    checks++;
    if (stall_cnt !== exp) begin
      errs++;
      $display("FAIL %s stall_cnt: got %0d expected %0d", nm, stall_cnt, exp);
    end
  endtask

  // Drive one cycle of inputs, check controls mid-cycle, then let the edge happen.
  task automatic step(input vec_t v, input string nm, input int idx);
    drive(v);
    @(negedge clk);
    chk_out(v.exp, nm, idx);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_OFF));
    rst = 1'b0;
    @(negedge clk);
    chk_out(E_OFF, "reset_outs", 0);
    chk_cnt(16'd0, "reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  vec_t tbl[11];
  vec_t seq_c[7];
  vec_t seq_d[7];

  initial begin
    rst = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_OFF));

    tbl[0]  = mk(5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0, 0, 0, E_RUN);
    tbl[1]  = mk(5'd1,  5'd0,  1, 0, 1, 5'd1,  0, 0, 0, 0, E_LUH);
    tbl[2]  = mk(5'd3,  5'd7,  0, 1, 1, 5'd7,  0, 0, 0, 0, E_LUH);
    tbl[3]  = mk(5'd0,  5'd0,  1, 1, 1, 5'd0,  0, 0, 0, 0, E_RUN);
    tbl[4]  = mk(5'd4,  5'd0,  0, 0, 1, 5'd4,  0, 0, 0, 0, E_RUN);
    tbl[5]  = mk(5'd4,  5'd4,  1, 1, 0, 5'd4,  0, 0, 0, 0, E_RUN);
    tbl[6]  = mk(5'd1,  5'd0,  1, 0, 1, 5'd1,  1, 0, 0, 0, E_RED);
    tbl[7]  = mk(5'd2,  5'd5,  1, 1, 1, 5'd3,  0, 0, 0, 0, E_RUN);
    tbl[8]  = mk(5'd0,  5'd0,  0, 0, 0, 5'd0,  1, 0, 0, 0, E_RED);
    tbl[9]  = mk(5'd31, 5'd0,  1, 0, 1, 5'd31, 0, 1, 1, 0, E_LUH);
    tbl[10] = mk(5'd9,  5'd12, 1, 1, 1, 5'd12, 0, 0, 0, 0, E_LUH);

    // halt held; redirect arrives mid-drain; release after halted
    seq_c[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_DR);
    seq_c[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_DR);
    seq_c[2] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, E_DRR);
    seq_c[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_DR);
    seq_c[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_HL);
    seq_c[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_HL);
    seq_c[6] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN);

    // halt with a 2-cycle memory wait inside the drain
    seq_d[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_DR);
    seq_d[1] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, E_MW);
    seq_d[2] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, E_MW);
    seq_d[3] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, E_DR);
    seq_d[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_DR);
    seq_d[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_DR);
    seq_d[6] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_HL);

    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 11; i++) step(tbl[i], "table", i);
    chk_cnt(16'd4, "table");

    // single load-use bubble, then the bubble sits in EX
    do_reset();
    step(mk(5'd1, 0, 1, 0, 1, 5'd1, 0, 0, 0, 0, E_LUH), "luh", 0);
    step(mk(5'd1, 0, 1, 0, 0, 5'd0, 0, 0, 0, 0, E_RUN), "luh", 1);
    chk_cnt(16'd1, "luh");

    // three wait-state cycles then completion
    do_reset();
    for (int i = 0; i < 3; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_MW), "memwait", i);
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, E_RUN), "memwait", 3);
    chk_cnt(16'd3, "memwait");

    do_reset();
    for (int i = 0; i < 7; i++) step(seq_c[i], "halt", i);
    chk_cnt(16'd6, "halt");

    do_reset();
    for (int i = 0; i < 7; i++) step(seq_d[i], "halt_mw", i);
    chk_cnt(16'd7, "halt_mw");

    // asynchronous reset in the middle of a memory wait
    do_reset();
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_MW), "rst_mw", 0);
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_MW), "rst_mw", 1);
    #1;
    rst = 1'b0;
    #1;
    chk_out(E_OFF, "rst_mw_async", 2);
    chk_cnt(16'd0, "rst_mw_async");
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN), "rst_mw", 3);
    chk_cnt(16'd0, "rst_mw_after");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the five-stage pipeline. Drives the clock-enable and synchronous-clear inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. Resolves load-use hazards, EX-stage redirects, data-memory wait states and an external halt/drain request. Keeps a saturating stall-cycle counter for debug.

## Interface
- DRAIN_CYCLES, 3, cycles of bubble injection before HALTED (covers ID/EX..MEM/WB)
- CNT_W, 16, width of stall counter
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- id_rs, id_rt  in  5  source register numbers of the instruction in ID
- id_use_rs, id_use_rt  in  1  ID instruction actually reads rs / rt
- ex_RMEM  in  1  instruction in EX is a load
- ex_nd  in  5  destination register of the EX instruction
- ex_redirect  in  1  EX resolved a taken branch/jump; PC is being redirected
- mem_req  in  1  MEM-stage instruction accesses data memory (load or store)
- mem_ready  in  1  data memory completes the access this cycle
- halt_req  in  1  level request to drain and stop the pipeline
- pc_CE, ifid_CE, idex_CE, exmem_CE, memwb_CE  out  1  stage-register enables
- ifid_clr, idex_clr, memwb_clr  out  1  load a bubble (all-zero) into that register
- halted  out  1  pipeline fully drained and stopped
- stall_cnt  out  CNT_W  saturating count of cycles with pc_CE=0

## Operation
- States: RUN, MEM_WAIT, DRAIN, HALTED. Reset state RUN.
- Load-use hazard: luh = ex_RMEM & ex_nd!=0 & ((id_use_rs & id_rs==ex_nd) | (id_use_rt & id_rt==ex_nd)).
- Memory wait: mw = mem_req & !mem_ready.
- RUN, priority high->low:
  - mw: pc/ifid/idex/exmem CE=0, memwb_CE=1 with memwb_clr=1; next MEM_WAIT.
  - ex_redirect: all CE=1, ifid_clr=1, idex_clr=1; luh ignored.
  - luh: pc_CE=ifid_CE=0, idex_CE=1 with idex_clr=1, exmem/memwb CE=1.
  - halt_req: pc_CE=ifid_CE=0, idex_clr=1, rest advance; counter loads DRAIN_CYCLES-1; next DRAIN.
  - else all CE=1, all clr=0.
- MEM_WAIT: same outputs as mw in RUN while mw holds; on mem_ready the cycle behaves as RUN (redirect/luh/halt evaluated), return-state RUN or DRAIN as recorded on entry.
- DRAIN: pc_CE=ifid_CE=0, idex_clr=1 each cycle; mw freezes as in MEM_WAIT and drain counter holds; counter==0 and !mw -> HALTED. ex_redirect during DRAIN: ifid_clr=1 additionally, drain continues.
- HALTED: all CE=0, all clr=0, halted=1. halt_req low -> RUN (resume from held PC next cycle).
- A clr has effect only with its CE=1; controller never asserts clr with CE=0.
- stall_cnt increments every cycle pc_CE=0 (incl. HALTED), saturates at all-ones.

## Timing
- All stage controls are combinational from state + current-cycle inputs; state, drain counter, return-state and stall_cnt are registered on posedge clk.
- rst low: asynchronously state=RUN, drain counter=0, stall_cnt=0, halted=0; all CE and clr outputs forced 0 while rst low.
- Load-use costs exactly one bubble; the following cycle ex_RMEM holds the bubble (0), so luh clears.
- Redirect costs two bubbles (IF/ID and ID/EX).
- Memory wait of N cycles adds N bubbles into MEM/WB and freezes earlier stages N cycles.
- halt_req to halted=1: DRAIN_CYCLES+1 cycles plus any memory-wait cycles.

## Structure
- Shared package: state encoding enum, DRAIN_CYCLES default, stage index constants.
- Single module; optional sub-module hazard_detect (combinational luh compare) reusable by forwarding logic.

## Test plan
- lw $1 in EX (ex_RMEM=1, ex_nd=1), ID reads rs=1 -> one cycle pc_CE=ifid_CE=0, idex_clr=1; next cycle all CE=1; stall_cnt=1.
- ex_nd=0 with load and id_rs=0 -> no stall.
- ex_redirect=1 with simultaneous luh -> ifid_clr=idex_clr=1, pc_CE=1, no stall.
- mem_req=1, mem_ready low 3 cycles -> 3 cycles exmem_CE=0, memwb_clr=1; 4th cycle all advance; stall_cnt=3.
- halt_req pulse-held in RUN -> halted=1 after 4 cycles; 2-cycle mem wait inserted mid-drain -> halted after 6; halt_req low -> RUN, pc_CE=1 next cycle.
- rst low mid-MEM_WAIT -> all outputs 0 immediately, state RUN, stall_cnt=0 after release.
